// File: rtl/latency_mem_pkg.sv
`default_nettype none
// latency_mem_pkg: FSM states, counter width and address-decode helpers
// shared by the latency_mem memory model and its latency counter.
package latency_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_W = 8;

  function automatic logic [31:0] word_index(input logic [31:0] addr, input int data_w);
    return addr / 32'(data_w / 8);
  endfunction

  function automatic logic is_mapped(input logic [31:0] addr, input int depth, input int data_w);
    return word_index(addr, data_w) < 32'(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/latency_mem_counter.sv
`default_nettype none
// latency_counter: 8-bit cycle counter with synchronous clear, enable and a
// terminal-count flag raised while the count equals lat_i-1.
module latency_counter
  import latency_mem_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] lat_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == (lat_i - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/latency_mem.sv
`default_nettype none
// latency_mem: PicoRV32 native-bus memory model with programmable read/write
// latency, an out-of-range error flag and a memory-mapped byte output port.
module latency_mem
  import latency_mem_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 32768,
  parameter int          READ_LAT  = 10,
  parameter int          WRITE_LAT = 15,
  parameter logic [31:0] OUT_ADDR  = 32'h1000_0000,
  parameter string       INIT_FILE = "firmware.hex"
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W/8-1:0]   mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_err,
  output logic [7:0]            out_byte,
  output logic                  out_byte_en
);

  localparam int c_NB = DATA_W / 8;
  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The image named by INIT_FILE is loaded into the array by the surrounding environment.
  logic w_unused_init;
  assign w_unused_init = (INIT_FILE == "");

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [c_NB-1:0]     wstrb_q, wstrb_d;
  logic [CNT_W-1:0]    lat_q, lat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [7:0]          obyte_q, obyte_d;
  logic                oen_q, oen_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                w_cnt_load;
  logic                w_cnt_en;
  logic                w_cnt_tc;
  logic                w_is_read;
  logic                w_mapped;
  logic                w_is_out;
  logic                w_wr_en;
  logic [c_AW-1:0]     w_idx;

  latency_counter u_counter (
    .clk    (clk),
    .resetn (resetn),
    .load_i (w_cnt_load),
    .en_i   (w_cnt_en),
    .lat_i  (lat_q),
    .tc_o   (w_cnt_tc)
  );

  // Decode always works on the latched request, never on the live bus.
  assign w_is_read = (wstrb_q == '0);
  assign w_mapped  = is_mapped(addr_q, DEPTH, DATA_W);
  assign w_is_out  = !w_is_read && (addr_q == OUT_ADDR);
  assign w_idx     = c_AW'(word_index(addr_q, DATA_W));
  assign w_wr_en   = (state_q == BUSY) && w_cnt_tc && w_mapped && !w_is_read;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    lat_d      = lat_q;
    rdata_d    = rdata_q;
    obyte_d    = obyte_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    oen_d      = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          state_d    = BUSY;
          addr_d     = mem_addr;
          wdata_d    = mem_wdata;
          wstrb_d    = mem_wstrb;
          lat_d      = (mem_wstrb == '0) ? CNT_W'(READ_LAT) : CNT_W'(WRITE_LAT);
          w_cnt_load = 1'b1;
        end
      end
      BUSY: begin
        w_cnt_en = 1'b1;
        if (w_cnt_tc) begin
          state_d = DONE;
          ready_d = 1'b1;
          if (w_mapped) begin
            if (w_is_read) begin
              rdata_d = mem_q[w_idx];
            end
          end else if (w_is_out) begin
            obyte_d = wdata_q[7:0];
            oen_d   = 1'b1;
          end else begin
            err_d = 1'b1;
            if (w_is_read) begin
              rdata_d = '0;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      obyte_q <= '0;
      oen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      obyte_q <= obyte_d;
      oen_q   <= oen_d;
    end
  end

  // Array contents survive reset; an aborted write never reaches the DONE edge.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < c_NB; i++) begin
        if (wstrb_q[i]) begin
          mem_q[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign mem_ready   = ready_q;
  assign mem_rdata   = rdata_q;
  assign mem_err     = err_q;
  assign out_byte    = obyte_q;
  assign out_byte_en = oen_q;

endmodule
`default_nettype wire

// File: tb/tb_latency_mem.sv
`timescale 1ns/1ps
`default_nettype none
// tb_latency_mem: directed checks of two latency_mem configurations
// (32-bit, 10/15 cycles and 64-bit, 1/3 cycles).
module tb_latency_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;

  logic        a_valid;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_wstrb;
  logic        a_ready, a_err, a_oen;
  logic [31:0] a_rdata;
  logic [7:0]  a_ob;

  logic        b_valid;
  logic [31:0] b_addr;
  logic [63:0] b_wdata;
  logic [7:0]  b_wstrb;
  logic        b_ready, b_err, b_oen;
  logic [63:0] b_rdata;
  logic [7:0]  b_ob;

  int n_checks = 0;
  int n_errors = 0;

  latency_mem #(
    .DATA_W(32), .DEPTH(32768), .READ_LAT(10), .WRITE_LAT(15),
    .OUT_ADDR(32'h1000_0000), .INIT_FILE("")
  ) dut_a (
    .clk(clk), .resetn(resetn), .mem_valid(a_valid), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_wstrb(a_wstrb), .mem_ready(a_ready),
    .mem_rdata(a_rdata), .mem_err(a_err), .out_byte(a_ob), .out_byte_en(a_oen)
  );

  latency_mem #(
    .DATA_W(64), .DEPTH(1024), .READ_LAT(1), .WRITE_LAT(3),
    .OUT_ADDR(32'h1000_0000), .INIT_FILE("")
  ) dut_b (
    .clk(clk), .resetn(resetn), .mem_valid(b_valid), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_wstrb(b_wstrb), .mem_ready(b_ready),
    .mem_rdata(b_rdata), .mem_err(b_err), .out_byte(b_ob), .out_byte_en(b_oen)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after the accepting edge; returns cycles until mem_ready.
  task automatic wait_a(output int lat, output logic [31:0] rd, output logic er,
                        output logic oe, output logic [7:0] ob);
    lat = 0;
    while (a_ready !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = a_rdata; er = a_err; oe = a_oen; ob = a_ob;
    @(posedge clk); #1;
    check("a_ready_pulse", {63'd0, a_ready}, 64'd0);
    check("a_err_pulse",   {63'd0, a_err},   64'd0);
    check("a_oen_pulse",   {63'd0, a_oen},   64'd0);
  endtask

  task automatic txa(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output int lat, output logic [31:0] rd, output logic er,
                     output logic oe, output logic [7:0] ob);
    a_addr = a; a_wdata = d; a_wstrb = s; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    wait_a(lat, rd, er, oe, ob);
  endtask

  task automatic txb(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                     output int lat, output logic [63:0] rd, output logic er);
    b_addr = a; b_wdata = d; b_wstrb = s; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    lat = 0;
    while (b_ready !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = b_rdata; er = b_err;
    @(posedge clk); #1;
    check("b_ready_pulse", {63'd0, b_ready}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [63:0] rdb;
    logic        er, oe, seen;
    logic [7:0]  ob;
    logic [11:0] pulses;

    resetn = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
    b_valid = 1'b0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, a_ready}, 64'd0);
    check("rst_rdata", {32'd0, a_rdata}, 64'd0);
    check("rst_err",   {63'd0, a_err},   64'd0);
    check("rst_obyte", {56'd0, a_ob},    64'd0);
    check("rst_oen",   {63'd0, a_oen},   64'd0);
    check("rst_b_rdata", b_rdata, 64'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // Preload word 4 and word 8 through the bus.
    txa(32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er, oe, ob);
    check("wr_lat", lat, 15);
    txa(32'h20, 32'hAABBCCDD, 4'hF, lat, rd, er, oe, ob);
    check("wr_err", {63'd0, er}, 64'd0);

    txa(32'h10, 32'h0, 4'h0, lat, rd, er, oe, ob);
    check("rd_lat",   lat, 10);
    check("rd_data",  {32'd0, rd}, 64'hDEADBEEF);
    check("rd_err",   {63'd0, er}, 64'd0);

    txa(32'h20, 32'h11223344, 4'b0101, lat, rd, er, oe, ob);
    check("strb_wr_lat", lat, 15);
    txa(32'h20, 32'h0, 4'h0, lat, rd, er, oe, ob);
    check("strb_rd_data", {32'd0, rd}, 64'hAA22CC44);

    txa(32'h0002_0000, 32'h0, 4'h0, lat, rd, er, oe, ob);
    check("oor_rd_data", {32'd0, rd}, 64'd0);
    check("oor_rd_err",  {63'd0, er}, 64'd1);
    txa(32'h0002_0000, 32'hCAFEF00D, 4'hF, lat, rd, er, oe, ob);
    check("oor_wr_err",  {63'd0, er}, 64'd1);
    check("oor_wr_lat",  lat, 15);
    txa(32'h1000_0000, 32'h0, 4'h0, lat, rd, er, oe, ob);
    check("out_rd_err",  {63'd0, er}, 64'd1);
    check("out_rd_oen",  {63'd0, oe}, 64'd0);

    txa(32'h20, 32'h0, 4'h0, lat, rd, er, oe, ob);
    check("reread_data", {32'd0, rd}, 64'hAA22CC44);

    txa(32'h1000_0000, 32'h0000_0041, 4'h1, lat, rd, er, oe, ob);
    check("out_oen",   {63'd0, oe}, 64'd1);
    check("out_byte",  {56'd0, ob}, 64'h41);
    check("out_err",   {63'd0, er}, 64'd0);
    check("out_rdata_hold", {32'd0, rd}, 64'hAA22CC44);
    check("out_lat",   lat, 15);

    // Abort a write to word 4 at cycle 7.
    a_addr = 32'h10; a_wdata = 32'h55667788; a_wstrb = 4'hF; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      seen = seen | a_ready;
    end
    #1 resetn = 1'b0;
    #1;
    check("abort_rdata", {32'd0, a_rdata}, 64'd0);
    check("abort_obyte", {56'd0, a_ob},    64'd0);
    check("abort_oen",   {63'd0, a_oen},   64'd0);
    check("abort_err",   {63'd0, a_err},   64'd0);
    repeat (2) begin
      @(posedge clk); #1;
      seen = seen | a_ready;
    end
    check("abort_no_ready", {63'd0, seen}, 64'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    txa(32'h10, 32'h0, 4'h0, lat, rd, er, oe, ob);
    check("abort_word_kept", {32'd0, rd}, 64'hDEADBEEF);

    // Request held through reset is accepted on the first edge after release.
    #1 resetn = 1'b0;
    a_addr = 32'h24; a_wdata = 32'h99AABBCC; a_wstrb = 4'hF; a_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    wait_a(lat, rd, er, oe, ob);
    check("held_wr_lat", lat, 15);
    txa(32'h24, 32'h0, 4'h0, lat, rd, er, oe, ob);
    check("held_wr_data", {32'd0, rd}, 64'h99AABBCC);

    // 64-bit configuration.
    txb(32'h40, 64'h0123_4567_89AB_CDEF, 8'hFF, lat, rdb, er);
    check("b_wr_lat", lat, 3);
    txb(32'h40, 64'hA500_0000_0000_0000, 8'h80, lat, rdb, er);
    check("b_lane7_lat", lat, 3);
    txb(32'h40, 64'h0, 8'h00, lat, rdb, er);
    check("b_rd_lat",  lat, 1);
    check("b_rd_data", rdb, 64'hA523_4567_89AB_CDEF);
    check("b_rd_err",  {63'd0, er}, 64'd0);

    b_addr = 32'h40; b_wstrb = 8'h00; b_valid = 1'b1;
    pulses = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      pulses[c] = b_ready;
    end
    b_valid = 1'b0;
    check("b_b2b_pulses", {52'd0, pulses}, 64'h492);
    check("b_b2b_data", b_rdata, 64'hA523_4567_89AB_CDEF);
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
